// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, fetches through a req/ack memory port
// with a timeout, and presents one instruction per execute window.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    input  logic        hold,
    input  logic        jump,
    input  logic        pcsrc,
    input  logic [31:0] pcbranch,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        ERR
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [31:0] next_pc;

    assign imem_addr = pc;
    assign pcplus4   = pc + 32'd4;

    // NOTE: every branch assigns next_pc, so no latch is inferred.
    always_comb begin
        if (jump)
            next_pc = {pcplus4[31:28], instr[25:0], 2'b00};
        else if (pcsrc)
            next_pc = pcbranch;
        else
            next_pc = pcplus4;
    end

    // imem_req, instr_valid and fetch_err are registered alongside the state so
    // they are glitch-free and drop asynchronously with reset_n.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
            cnt         <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        cnt         <= 16'h0;
                        state       <= EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        cnt       <= 16'h0;
                        state     <= ERR;
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                EXEC: begin
                    if (!hold) begin
                        pc          <= next_pc;
                        state       <= FETCH;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                    end
                end
                ERR: begin
                    // Only reset leaves the error state.
                    fetch_err <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: transaction-level model of the PC and
// the latched instruction, driven by directed and randomized fetch/exec windows.
module tb_ifetch_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        hold;
    logic        jump;
    logic        pcsrc;
    logic [31:0] pcbranch;
    logic        fetch_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: address of the current instruction and its word.
    logic [31:0] mpc;
    logic [31:0] mword;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pcplus4(pcplus4),
        .hold(hold), .jump(jump), .pcsrc(pcsrc), .pcbranch(pcbranch),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1, "watchdog");
    end

    // One fetch of 'lat' cycles, acked in the last cycle with 'word'.
    task automatic do_fetch(input int lat, input logic [31:0] word, input string tag);
        for (int k = 1; k <= lat; k++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== mpc || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
                n_err++;
                $display("FAIL %s fetch cyc %0d: req=%b addr=%h valid=%b err=%b, required req=1 addr=%h valid=0 err=0",
                         tag, k, imem_req, imem_addr, instr_valid, fetch_err, mpc);
            end
            imem_ack   = (k == lat);
            imem_rdata = (k == lat) ? word : 32'($urandom());
            @(negedge clk);
        end
        imem_ack   = 1'b0;
        imem_rdata = 32'($urandom());
        mword      = word;
    endtask

    // One execute window stretched by 'nhold' hold cycles; junk on the control
    // inputs and stray acks while held must be ignored.
    task automatic do_exec(input int nhold, input logic j, input logic ps,
                           input logic [31:0] br, input string tag);
        logic [31:0] p4;
        for (int h = 0; h <= nhold; h++) begin
            n_cmp++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== mword || pc !== mpc) begin
                n_err++;
                $display("FAIL %s exec cyc %0d: valid=%b req=%b instr=%h pc=%h, required valid=1 req=0 instr=%h pc=%h",
                         tag, h, instr_valid, imem_req, instr, pc, mword, mpc);
            end
            n_cmp++;
            if (pcplus4 !== mpc + 32'd4) begin
                n_err++;
                $display("FAIL %s pcplus4: got %h, required %h", tag, pcplus4, mpc + 32'd4);
            end
            if (h < nhold) begin
                hold       = 1'b1;
                jump       = 1'($urandom());
                pcsrc      = 1'($urandom());
                pcbranch   = 32'($urandom());
                imem_ack   = 1'($urandom());
                imem_rdata = 32'($urandom());
            end else begin
                hold     = 1'b0;
                jump     = j;
                pcsrc    = ps;
                pcbranch = br;
                imem_ack = 1'b0;
            end
            @(negedge clk);
        end
        hold     = 1'b0;
        jump     = 1'b0;
        pcsrc    = 1'b0;
        pcbranch = 32'($urandom());
        p4 = mpc + 32'd4;
        if (j)
            mpc = (p4 & 32'hF000_0000) | ((mword & 32'h03FF_FFFF) << 2);
        else if (ps)
            mpc = br;
        else
            mpc = p4;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; hold = 1'b0;
        jump = 1'b0; pcsrc = 1'b0; pcbranch = 32'h0;
        mpc = 32'h0; mword = 32'h0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
            n_err++;
            $display("FAIL reset values: req=%b valid=%b err=%b pc=%h instr=%h, required all zero",
                     imem_req, instr_valid, fetch_err, pc, instr);
        end
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL idle req: got %b, required 0", imem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_first_fetch();
        do_fetch(1, 32'h2008_0005, "first");
        do_exec(0, 1'b0, 1'b0, 32'h0, "first");
        n_cmp++;
        if (imem_addr !== 32'h0000_0004) begin
            n_err++;
            $display("FAIL first next addr: got %h, required 00000004", imem_addr);
        end
    endtask

    task automatic test_latency();
        // Two 3-cycle fetches back to back: the second only fits the timeout
        // if the counter was cleared by the first ack.
        do_fetch(3, 32'hDEAD_0001, "lat3a");
        do_exec(0, 1'b0, 1'b0, 32'h0, "lat3a");
        do_fetch(3, 32'hDEAD_0002, "lat3b");
        do_exec(1, 1'b0, 1'b0, 32'h0, "lat3b");
    endtask

    task automatic test_jump_priority();
        do_fetch(1, 32'h1111_2222, "jp_setup");
        do_exec(0, 1'b0, 1'b1, 32'h0040_0000, "jp_setup");
        do_fetch(2, 32'h0800_0010, "jp");
        do_exec(0, 1'b1, 1'b1, 32'h0000_0800, "jp");
        n_cmp++;
        if (pc !== 32'h0000_0040) begin
            n_err++;
            $display("FAIL jump over branch: pc=%h, required 00000040", pc);
        end
    endtask

    task automatic test_hold_branch();
        do_fetch(1, 32'h1234_5678, "hold");
        do_exec(2, 1'b0, 1'b1, 32'h0000_0100, "hold");
        n_cmp++;
        if (pc !== 32'h0000_0100) begin
            n_err++;
            $display("FAIL hold branch: pc=%h, required 00000100", pc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_fetch(int'($urandom_range(1, TMO)), 32'($urandom()), "rand");
            do_exec(int'($urandom_range(0, 2)), 1'($urandom()), 1'($urandom()),
                    32'($urandom()) & 32'hFFFF_FFFC, "rand");
        end
    endtask

    task automatic test_wrap_and_reset();
        // EXEC at the top of memory wraps to zero with no error.
        do_fetch(1, 32'h0, "wrap_setup");
        do_exec(0, 1'b0, 1'b1, 32'hFFFF_FFFC, "wrap_setup");
        do_fetch(2, 32'hCAFE_F00D, "wrap");
        do_exec(0, 1'b0, 1'b0, 32'h0000_0000, "wrap");
        n_cmp++;
        if (pc !== 32'h0 || fetch_err !== 1'b0) begin
            n_err++;
            $display("FAIL wrap: pc=%h err=%b, required pc=00000000 err=0", pc, fetch_err);
        end
        // Reset in the middle of an outstanding fetch at the top address.
        do_fetch(1, 32'h0, "rst_setup");
        do_exec(0, 1'b0, 1'b1, 32'hFFFF_FFFC, "rst_setup");
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL pre-reset fetch: req=%b addr=%h, required req=1 addr=fffffffc", imem_req, imem_addr);
        end
        imem_ack = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async reset: req=%b pc=%h instr=%h valid=%b, required req=0 pc=0 instr=0 valid=0",
                     imem_req, pc, instr, instr_valid);
        end
        mpc = 32'h0; mword = 32'h0;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL idle after reset: req=%b, required 0", imem_req);
        end
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL stray ack in idle: valid=%b instr=%h req=%b, required valid=0 instr=0 req=1",
                     instr_valid, instr, imem_req);
        end
        do_fetch(2, 32'h2008_0005, "post_rst");
        do_exec(0, 1'b0, 1'b0, 32'h0, "post_rst");
    endtask

    task automatic test_timeout();
        for (int k = 1; k <= TMO; k++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
                n_err++;
                $display("FAIL timeout wait cyc %0d: req=%b err=%b, required req=1 err=0", k, imem_req, fetch_err);
            end
            imem_ack = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== mpc) begin
                n_err++;
                $display("FAIL sticky err cyc %0d: err=%b req=%b valid=%b pc=%h, required err=1 req=0 valid=0 pc=%h",
                         k, fetch_err, imem_req, instr_valid, pc, mpc);
            end
            imem_ack   = 1'b1;
            imem_rdata = 32'($urandom());
            hold       = 1'($urandom());
            @(negedge clk);
        end
        imem_ack = 1'b0;
        hold = 1'b0;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (fetch_err !== 1'b0 || pc !== 32'h0) begin
            n_err++;
            $display("FAIL err reset: err=%b pc=%h, required err=0 pc=00000000", fetch_err, pc);
        end
        mpc = 32'h0; mword = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_fetch(1, 32'h0000_0000, "after_err");
        do_exec(0, 1'b0, 1'b0, 32'h0, "after_err");
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_latency();
        test_jump_priority();
        test_hold_branch();
        test_random();
        test_wrap_and_reset();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
